// File: rtl/cnn_pkg.sv
// Shared image geometry, pixel format and streaming FSM encoding for the
// CNN input path.
package cnn_pkg;

    localparam int IMG_WIDTH  = 28;
    localparam int IMG_HEIGHT = 28;
    localparam int DATA_BITS  = 8;
    localparam int ADDR_BITS  = $clog2(IMG_WIDTH * IMG_HEIGHT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one synchronous write port, one read port
// with a registered (1-cycle) output. Array contents are never reset.
module frame_ram #(
    parameter int DEPTH     = 784,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_BITS-1:0]        wr_addr,
    input  logic signed [DATA_BITS-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_BITS-1:0]        rd_addr,
    output logic signed [DATA_BITS-1:0] rd_data
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    logic signed [DATA_BITS-1:0] mem_q [DEPTH];
    logic signed [DATA_BITS-1:0] rd_data_q;

    // Write port; addresses past the frame are ignored.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/img_stream_src.sv
// Streams a stored image frame out in raster order, one pixel per un-paused
// cycle, with a frame-done pulse on the last pixel.
module img_stream_src #(
    parameter int  WIDTH     = cnn_pkg::IMG_WIDTH,
    parameter int  HEIGHT    = cnn_pkg::IMG_HEIGHT,
    parameter int  DATA_BITS = cnn_pkg::DATA_BITS,
    localparam int ADDR_BITS = $clog2(WIDTH * HEIGHT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_BITS-1:0]        wr_addr,
    input  logic signed [DATA_BITS-1:0] wr_data,
    input  logic                        start,
    input  logic                        pause,
    output logic                        valid_out,
    output logic signed [DATA_BITS-1:0] data_out,
    output logic                        busy,
    output logic                        done,
    output logic                        wr_err
);

    import cnn_pkg::*;

    localparam int                   NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wr_err_q, wr_err_d;
    logic                   issue_s;
    logic                   last_s;
    logic                   ram_we_s;

    assign last_s = (rd_addr_q == LAST_ADDR);

    // State, address counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (!pause && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read issue, address advance and registered-output next values.
    always_comb begin
        issue_s   = (state_q == ST_STREAM) && !pause;
        rd_addr_d = rd_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q;
                end
            end
            ST_STREAM: begin
                // Saturate on the last pixel; the next start rewinds to 0.
                if (issue_s && !last_s) begin
                    rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                end else begin
                    rd_addr_d = rd_addr_q;
                end
            end
            default: rd_addr_d = '0;
        endcase
        valid_d  = issue_s;
        done_d   = issue_s && last_s;
        busy_d   = (state_d == ST_STREAM);
        wr_err_d = wr_en && (state_q == ST_STREAM);
        ram_we_s = wr_en && (state_q == ST_IDLE);
    end

    frame_ram #(
        .DEPTH     (NPIX),
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_frame_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue_s),
        .rd_addr (rd_addr_q),
        .rd_data (data_out)
    );

    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;

endmodule
